// File: rtl/ahbl_apb_pkg.sv
// ahbl_apb_pkg: shared state encoding, AHB transfer encodings and strobe helper for the bridge
package ahbl_apb_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  function automatic logic [3:0] pstrb_gen(input logic write, input logic [2:0] size, input logic [1:0] addr);
    return !write ? 4'b0000 :
           size == HSIZE_WORD ? 4'b1111 :
           size == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
           size == HSIZE_BYTE ? 4'b0001 << addr : 4'b0000;
  endfunction
endpackage

// File: rtl/apb_slave_mux.sv
// apb_slave_mux: one-hot PSEL decode and response select of the addressed APB peripheral
module apb_slave_mux
  import ahbl_apb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic            active,
  input  logic [3:0]      idx,
  input  logic [32*N-1:0] prdata,
  input  logic [N-1:0]    pready,
  input  logic [N-1:0]    pslverr,
  output logic [N-1:0]    psel,
  output logic [31:0]     rdata,
  output logic            ready,
  output logic            slverr
);
  logic [511:0] rd_all;
  logic [15:0]  rdy_all;
  logic [15:0]  err_all;
  assign rd_all  = 512'(prdata);
  assign rdy_all = 16'(pready);
  assign err_all = 16'(pslverr);
  assign psel    = N'(active ? 16'd1 << idx : 16'd0);
  assign rdata   = rd_all[{idx, 5'd0} +: 32];
  assign ready   = rdy_all[idx];
  assign slverr  = err_all[idx];
endmodule

// File: rtl/ahbl_apb_bridge.sv
// ahbl_apb_bridge: AHB-lite slave turning each transfer into one APB4 SETUP/ACCESS sequence
module ahbl_apb_bridge
  import ahbl_apb_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int SEL_LSB    = 16,
  parameter int PADDR_W    = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic                     HREADY,
  input  logic [31:0]              HWDATA,
  output logic                     HREADYOUT,
  output logic [63:0]              HRDATA,
  output logic                     HRESP,
  output logic [PADDR_W-1:0]       PADDR,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  output logic [3:0]               PSTRB,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY,
  input  logic [NUM_SLAVES-1:0]    PSLVERR
);
  state_t      state, state_nx;
  logic [3:0]  idx, haddr_idx;
  logic [31:0] rd_q, sel_rdata;
  logic        sel_ready, sel_err, accept, in_range, p_active;
  logic        unused_haddr;
  assign haddr_idx    = HADDR[SEL_LSB+3:SEL_LSB];
  assign in_range     = 32'(haddr_idx) < NUM_SLAVES;
  assign accept       = HSEL && HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ} && HREADY &&
                        state inside {IDLE, DONE, ERR2};
  assign unused_haddr = ^HADDR;
  assign PWDATA       = HWDATA;
  assign HRDATA       = {rd_q, rd_q};
  apb_slave_mux #(.N(NUM_SLAVES)) u_mux (
    .active (p_active),
    .idx    (idx),
    .prdata (PRDATA),
    .pready (PREADY),
    .pslverr(PSLVERR),
    .psel   (PSEL),
    .rdata  (sel_rdata),
    .ready  (sel_ready),
    .slverr (sel_err)
  );
  // State register; async reset drops PSEL/PENABLE immediately
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= IDLE;
    else state <= state_nx;
  // Address-phase capture on accept and read-data capture on a clean APB completion
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PSTRB  <= 4'b0000;
      idx    <= 4'd0;
      rd_q   <= 32'd0;
    end else begin
      if (accept) begin
        PADDR  <= HADDR[PADDR_W-1:0];
        PWRITE <= HWRITE;
        PSTRB  <= pstrb_gen(HWRITE, HSIZE, HADDR[1:0]);
        idx    <= haddr_idx;
      end
      if (state == ACCESS && sel_ready && !sel_err && !PWRITE) rd_q <= sel_rdata;
    end
  // Next-state and bus-facing handshake outputs
  always_comb begin
    state_nx  = state;
    HREADYOUT = state inside {IDLE, DONE, ERR2};
    HRESP     = state inside {ERR1, ERR2};
    PENABLE   = state == ACCESS;
    p_active  = state inside {SETUP, ACCESS};
    case (state)
      IDLE, DONE, ERR2: state_nx = !accept ? IDLE : in_range ? SETUP : ERR1;
      SETUP:            state_nx = ACCESS;
      ACCESS:           state_nx = !sel_ready ? ACCESS : sel_err ? ERR1 : DONE;
      ERR1:             state_nx = ERR2;
      default:          state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// tb_ahbl_apb_bridge: randomized AHB transfers against a transaction-level bridge model
module tb_ahbl_apb_bridge;
  localparam int NS = 8;
  logic            HCLK = 0, HRESETn = 0, HSEL = 0, HWRITE = 0, HREADY = 1;
  logic [31:0]     HADDR = 0, HWDATA = 0;
  logic [1:0]      HTRANS = 0;
  logic [2:0]      HSIZE = 0;
  logic            HREADYOUT, HRESP, PENABLE, PWRITE;
  logic [63:0]     HRDATA;
  logic [15:0]     PADDR;
  logic [NS-1:0]   PSEL;
  logic [31:0]     PWDATA;
  logic [3:0]      PSTRB;
  logic [32*NS-1:0] PRDATA = 0;
  logic [NS-1:0]   PREADY = 0, PSLVERR = 0;
  int              n_tests = 0, n_fail = 0;
  int              p_stall = 0, acc = 0;
  bit              p_err = 0;
  logic [31:0]     p_rdata = 0;
  logic [63:0]     exp_hr = 0;

  ahbl_apb_bridge #(.NUM_SLAVES(NS), .SEL_LSB(16), .PADDR_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Peripheral model: selected slave is ready after p_stall waited ACCESS cycles; others return garbage
  always @(negedge HCLK) begin
    int s;
    logic [NS-1:0] r, e;
    s = -1;
    for (int i = 0; i < NS; i++) if (PSEL[i]) s = i;
    if (PSEL != 0 && !PENABLE) acc = 0;
    else if (PENABLE) acc++;
    r = NS'($urandom);
    e = NS'($urandom);
    for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = $urandom;
    if (s >= 0) begin
      r[s] = PENABLE && acc > p_stall;
      e[s] = p_err;
      PRDATA[32*s +: 32] = p_rdata;
    end
    PREADY = r;
    PSLVERR = e;
  end

  // Called at a negedge with the bridge ready; returns at the negedge where it is ready again
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [31:0] wdata, input int stall, input bit err, input logic [31:0] rdata);
    int idx, lows, nb, base;
    bit bad;
    logic [NS-1:0] psel_seen;
    logic [15:0] paddr_s;
    logic [3:0] pstrb_s, mstrb;
    logic pwrite_s, hresp_low;
    logic [31:0] pwdata_s;
    idx = int'(addr[19:16]);
    bad = idx >= NS;
    p_stall = stall; p_err = err; p_rdata = rdata;
    HSEL = 1; HTRANS = 2'($urandom_range(2, 3)); HADDR = addr; HWRITE = wr; HSIZE = size; HREADY = 1;
    @(posedge HCLK); #1;
    HTRANS = 0; HSEL = 1'($urandom); HWDATA = wdata; HADDR = $urandom; HWRITE = 1'($urandom);
    lows = 0; psel_seen = 0; hresp_low = 0;
    paddr_s = 0; pstrb_s = 0; pwrite_s = 0; pwdata_s = 0;
    forever begin
      @(negedge HCLK);
      if (HREADYOUT) break;
      lows++;
      psel_seen |= PSEL;
      hresp_low = HRESP;
      if (PENABLE) begin paddr_s = PADDR; pstrb_s = PSTRB; pwrite_s = PWRITE; pwdata_s = PWDATA; end
      if (lows > 64) begin chk("timeout", 64'(lows), 0); break; end
    end
    nb = 1 << size;
    base = (int'(addr[1:0]) / nb) * nb;
    mstrb = wr ? 4'(((1 << nb) - 1) << base) : 4'b0000;
    if (bad) begin
      chk("wait_states", 64'(lows), 1);
      chk("psel", 64'(psel_seen), 0);
      chk("hresp_wait", 64'(hresp_low), 1);
    end else begin
      chk("wait_states", 64'(lows), 64'(stall + 2 + (err ? 1 : 0)));
      chk("psel", 64'(psel_seen), 64'(1 << idx));
      chk("hresp_wait", 64'(hresp_low), 64'(err));
      chk("paddr", 64'(paddr_s), 64'(addr[15:0]));
      chk("pwrite", 64'(pwrite_s), 64'(wr));
      chk("pstrb", 64'(pstrb_s), 64'(mstrb));
      if (wr) chk("pwdata", 64'(pwdata_s), 64'(wdata));
      if (!err && !wr) exp_hr = {rdata, rdata};
    end
    chk("hresp_end", 64'(HRESP), 64'(bad || err));
    chk("hrdata", HRDATA, exp_hr);
  endtask

  // Non-accepted bus activity: the bridge must stay ready with no APB traffic
  task automatic idle(input int n);
    int mode;
    for (int k = 0; k < n; k++) begin
      mode = $urandom_range(0, 2);
      HADDR = $urandom; HWRITE = 1'($urandom);
      HSEL = mode != 0;
      HTRANS = mode == 1 ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      HREADY = mode != 2;
      @(negedge HCLK);
      chk("idle_ready", {HREADYOUT, HRESP, PENABLE, PSEL}, {1'b1, 1'b0, 1'b0, {NS{1'b0}}});
    end
    HSEL = 0; HTRANS = 0; HREADY = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    repeat (3) @(negedge HCLK);
    HRESETn = 1;
    @(negedge HCLK);
    chk("rst_hreadyout", 64'(HREADYOUT), 1);
    chk("rst_hresp", 64'(HRESP), 0);
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_apb", {PSEL, PENABLE, PWRITE, PADDR, PSTRB}, 0);
    xfer(32'h4003_0010, 0, 3'd2, 32'h0, 0, 0, 32'h1234_5678);
    chk("t1_hrdata", HRDATA, 64'h1234_5678_1234_5678);
    idle(2);
    xfer(32'h4001_0002, 1, 3'd0, 32'h00AB_0000, 3, 0, $urandom);
    idle(1);
    xfer(32'h4002_0000, 1, 3'd2, $urandom, 0, 1, $urandom);
    idle(1);
    xfer(32'h400C_0000, 0, 3'd2, 32'h0, 0, 0, $urandom);
    idle(1);
    xfer(32'h4000_0000, 0, 3'd2, 32'h0, 0, 0, 32'hCAFE_F00D);
    xfer(32'h4005_0004, 1, 3'd1, 32'h5555_AAAA, 0, 0, $urandom);
    idle(1);
    p_stall = 20; p_err = 0;
    HSEL = 1; HTRANS = 2'b10; HADDR = 32'h4006_0008; HWRITE = 0; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HTRANS = 0; HSEL = 0;
    repeat (3) @(negedge HCLK);
    chk("pre_rst_penable", 64'(PENABLE), 1);
    #2 HRESETn = 0;
    #1;
    chk("rst_mid_psel", 64'(PSEL), 0);
    chk("rst_mid_penable", 64'(PENABLE), 0);
    chk("rst_mid_hreadyout", 64'(HREADYOUT), 1);
    exp_hr = 0;
    chk("rst_mid_hrdata", HRDATA, exp_hr);
    @(negedge HCLK);
    HRESETn = 1;
    @(negedge HCLK);
    xfer(32'h4006_0008, 0, 3'd2, 32'h0, 1, 0, 32'h0BAD_BEEF);
    for (int t = 0; t < 40; t++) begin
      a = 32'h4000_0000 | (32'($urandom_range(0, 9)) << 16) | 32'($urandom_range(0, 16'hFFFF));
      xfer(a, 1'($urandom), 3'($urandom_range(0, 2)), $urandom, $urandom_range(0, 4),
           $urandom_range(0, 5) == 0, $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
